mem_stage_m2w: RTL and testbench

- Memory stage of the 5-stage MIPS pipeline.
- Takes the E/M-stage instruction bundle and performs stores (sw/sh/sb) into a word-organised data memory with byte enables.
- Reads the addressed word for loads and registers IR, PC+4, ALU result and memory word into the M/W pipeline register.
- The write-back stage consumes the M/W outputs and does all load extraction and sign-extension; this block returns the raw full word.

---
 rtl/mem_stage_m2w.sv | 144 ++++++++++++++
 tb/tb_mem_stage_m2w.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_m2w.sv
// rtl/mem_stage_m2w.sv - MIPS memory stage: byte-enabled stores, raw word read, M/W pipeline register
module mem_stage_m2w #(
   parameter int DM_WORDS = 4096,
   parameter int DM_AW    = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_E2M,
   input  logic [31:0] PC4_E2M,
   input  logic [31:0] ALUout_E2M,
   input  logic [31:0] RTdata_E2M,
   output logic [31:0] IR_M2W,
   output logic [31:0] PC4_M2W,
   output logic [31:0] ALUout_M2W,
   output logic [31:0] DMout_M2W,
   output logic [3:0]  DMbe,
   output logic        AddrErr
);

   localparam logic [5:0] OP_SW = 6'b101011;
   localparam logic [5:0] OP_SH = 6'b101001;
   localparam logic [5:0] OP_SB = 6'b101000;

   // Data memory; deliberately not cleared by reset.
   logic [31:0] mem [DM_WORDS];

   logic [5:0]       opcode;
   logic             is_sw;
   logic             is_sh;
   logic             is_sb;
   logic             is_store;
   logic [1:0]       byte_off;
   logic [DM_AW-1:0] word_idx;
   logic [31:0]      hi_bits;
   logic             out_of_range;
   logic             misaligned;
   logic             addr_err;
   logic [3:0]       be_raw;
   logic [3:0]       be_eff;
   logic [31:0]      wdata;
   logic [31:0]      rdata;

   logic [31:0] ir_q,  ir_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] dm_q,  dm_d;

   assign opcode   = IR_E2M[31:26];
   assign byte_off = ALUout_E2M[1:0];
   assign word_idx = ALUout_E2M[DM_AW+1:2];

   // Any address bit above the word index means the access falls outside memory.
   assign hi_bits      = ALUout_E2M >> (DM_AW + 2);
   assign out_of_range = |hi_bits;

   // Store decode and alignment check.
   always_comb begin
      is_sw      = 1'b0;
      is_sh      = 1'b0;
      is_sb      = 1'b0;
      misaligned = 1'b0;
      case (opcode)
         OP_SW: begin
            is_sw      = 1'b1;
            misaligned = (byte_off != 2'b00);
         end
         OP_SH: begin
            is_sh      = 1'b1;
            misaligned = byte_off[0];
         end
         OP_SB: begin
            is_sb      = 1'b1;
         end
         default: begin
            misaligned = 1'b0;
         end
      endcase
   end

   assign is_store = is_sw | is_sh | is_sb;
   assign addr_err = is_store & (misaligned | out_of_range);

   // Lane enables and replicated write data before error/reset gating.
   always_comb begin
      be_raw = 4'b0000;
      wdata  = RTdata_E2M;
      if (is_sw) begin
         be_raw = 4'b1111;
         wdata  = RTdata_E2M;
      end else if (is_sh) begin
         be_raw = byte_off[1] ? 4'b1100 : 4'b0011;
         wdata  = {RTdata_E2M[15:0], RTdata_E2M[15:0]};
      end else if (is_sb) begin
         be_raw = 4'b0001 << byte_off;
         wdata  = {4{RTdata_E2M[7:0]}};
      end
   end

   // An erroneous store or any cycle under reset writes nothing.
   assign be_eff  = (reset && !addr_err) ? be_raw : 4'b0000;
   assign DMbe    = be_eff;
   assign AddrErr = addr_err;

   // Out-of-range reads return zero rather than an aliased word.
   assign rdata = out_of_range ? 32'h0 : mem[word_idx];

   // Byte-lane writes; the read below sees the pre-write word at the same edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (be_eff[i]) begin
            mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Next-state of the M/W register: straight capture, the stage never stalls.
   always_comb begin
      ir_d  = IR_E2M;
      pc4_d = PC4_E2M;
      alu_d = ALUout_E2M;
      dm_d  = rdata;
   end

   // M/W pipeline register; reset yields an all-zero bundle that decodes as a nop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ir_q  <= 32'h0;
         pc4_q <= 32'h0;
         alu_q <= 32'h0;
         dm_q  <= 32'h0;
      end else begin
         ir_q  <= ir_d;
         pc4_q <= pc4_d;
         alu_q <= alu_d;
         dm_q  <= dm_d;
      end
   end

   assign IR_M2W     = ir_q;
   assign PC4_M2W    = pc4_q;
   assign ALUout_M2W = alu_q;
   assign DMout_M2W  = dm_q;

endmodule

// File: tb/tb_mem_stage_m2w.sv
// tb/tb_mem_stage_m2w.sv - table-driven scoreboard bench for mem_stage_m2w
module tb_mem_stage_m2w;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR_E2M, PC4_E2M, ALUout_E2M, RTdata_E2M;
   logic [31:0] IR_M2W, PC4_M2W, ALUout_M2W, DMout_M2W;
   logic [3:0]  DMbe;
   logic        AddrErr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [3:0]  be;
      logic        err;
      logic [31:0] dm;
      logic        chk_dm;
   } vec_t;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] dm;
      logic        chk_dm;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   mem_stage_m2w #(.DM_WORDS(4096), .DM_AW(12)) dut (
      .clk        (clk),
      .reset      (reset),
      .IR_E2M     (IR_E2M),
      .PC4_E2M    (PC4_E2M),
      .ALUout_E2M (ALUout_E2M),
      .RTdata_E2M (RTdata_E2M),
      .IR_M2W     (IR_M2W),
      .PC4_M2W    (PC4_M2W),
      .ALUout_M2W (ALUout_M2W),
      .DMout_M2W  (DMout_M2W),
      .DMbe       (DMbe),
      .AddrErr    (AddrErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ins(input logic [5:0] opc);
      return {opc, 5'd0, 5'd1, 16'h0};
   endfunction

   function automatic vec_t mk(input logic [31:0] ir, input logic [31:0] pc4,
                               input logic [31:0] alu, input logic [31:0] rt,
                               input logic [3:0] be, input logic err,
                               input logic [31:0] dm, input logic chk_dm);
      vec_t v;
      v.ir = ir; v.pc4 = pc4; v.alu = alu; v.rt = rt;
      v.be = be; v.err = err; v.dm = dm; v.chk_dm = chk_dm;
      return v;
   endfunction

   initial begin
      logic [31:0] SW, SH, SB, LW, ADDU;
      exp_t e;
      SW = ins(6'h2B); SH = ins(6'h29); SB = ins(6'h28); LW = ins(6'h23);
      ADDU = 32'h00221821;

      vecs.push_back(mk(SW,   32'h1000, 32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(LW,   32'h1004, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b1));
      vecs.push_back(mk(SW,   32'h1008, 32'h20,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(SH,   32'h100C, 32'h22,       32'h00001234, 4'hC, 1'b0, 32'hDEADBEEF, 1'b1));
      vecs.push_back(mk(SB,   32'h1010, 32'h21,       32'h000000AB, 4'h2, 1'b0, 32'h1234BEEF, 1'b1));
      vecs.push_back(mk(LW,   32'h1014, 32'h20,       32'h0,        4'h0, 1'b0, 32'h1234ABEF, 1'b1));
      vecs.push_back(mk(SW,   32'h1018, 32'h13,       32'h11111111, 4'h0, 1'b1, 32'hDEADBEEF, 1'b1));
      vecs.push_back(mk(SH,   32'h101C, 32'h21,       32'h00005555, 4'h0, 1'b1, 32'h1234ABEF, 1'b1));
      vecs.push_back(mk(LW,   32'h1020, 32'h10,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b1));
      vecs.push_back(mk(LW,   32'h1024, 32'h20,       32'h0,        4'h0, 1'b0, 32'h1234ABEF, 1'b1));
      vecs.push_back(mk(SW,   32'h1028, 32'h0,        32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(SW,   32'h102C, 32'h4000,     32'h99999999, 4'h0, 1'b1, 32'h0,        1'b1));
      vecs.push_back(mk(LW,   32'h1030, 32'h4000,     32'h0,        4'h0, 1'b0, 32'h0,        1'b1));
      vecs.push_back(mk(LW,   32'h1034, 32'h0,        32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1'b1));
      vecs.push_back(mk(SB,   32'h1038, 32'h23,       32'h00000077, 4'h8, 1'b0, 32'h1234ABEF, 1'b1));
      vecs.push_back(mk(LW,   32'h103C, 32'h20,       32'h0,        4'h0, 1'b0, 32'h7734ABEF, 1'b1));
      vecs.push_back(mk(SW,   32'h1040, 32'h30,       32'hA5A5A5A5, 4'hF, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(SH,   32'h1044, 32'h30,       32'hFFFF5678, 4'h3, 1'b0, 32'hA5A5A5A5, 1'b1));
      vecs.push_back(mk(LW,   32'h1048, 32'h30,       32'h0,        4'h0, 1'b0, 32'hA5A55678, 1'b1));
      vecs.push_back(mk(ADDU, 32'h3008, 32'h7,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(SW,   32'h1050, 32'h3FFC,     32'h01020304, 4'hF, 1'b0, 32'h0,        1'b0));
      vecs.push_back(mk(SB,   32'h1054, 32'h3FFF,     32'h00000042, 4'h8, 1'b0, 32'h01020304, 1'b1));
      vecs.push_back(mk(LW,   32'h1058, 32'h3FFC,     32'h0,        4'h0, 1'b0, 32'h42020304, 1'b1));
      vecs.push_back(mk(LW,   32'h105C, 32'h13,       32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b1));
      vecs.push_back(mk(SB,   32'h1060, 32'h4001,     32'h00000033, 4'h0, 1'b1, 32'h0,        1'b1));
      vecs.push_back(mk(SH,   32'h1064, 32'h80000000, 32'h00004444, 4'h0, 1'b1, 32'h0,        1'b1));
      vecs.push_back(mk(LW,   32'h1068, 32'h0,        32'h0,        4'h0, 1'b0, 32'hCAFEF00D, 1'b1));

      // Reset asserted from time zero with nonzero inputs.
      reset = 1'b0;
      IR_E2M = 32'h8C010004; PC4_E2M = 32'h44; ALUout_E2M = 32'h10; RTdata_E2M = 32'h55;
      #3;
      chk("reset_ir",  IR_M2W,     32'h0);
      chk("reset_pc4", PC4_M2W,    32'h0);
      chk("reset_alu", ALUout_M2W, 32'h0);
      chk("reset_dm",  DMout_M2W,  32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Table: comb outputs checked before the edge, M2W bundle checked after it.
      foreach (vecs[i]) begin
         IR_E2M = vecs[i].ir; PC4_E2M = vecs[i].pc4;
         ALUout_E2M = vecs[i].alu; RTdata_E2M = vecs[i].rt;
         #1;
         chk($sformatf("v%0d_be", i),  {28'h0, DMbe},     {28'h0, vecs[i].be});
         chk($sformatf("v%0d_err", i), {31'h0, AddrErr},  {31'h0, vecs[i].err});
         sb.push_back('{ir: vecs[i].ir, pc4: vecs[i].pc4, alu: vecs[i].alu,
                        dm: vecs[i].dm, chk_dm: vecs[i].chk_dm});
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL v%0d_sb_empty actual=0 expected=1", i);
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_ir", i),  IR_M2W,     e.ir);
            chk($sformatf("v%0d_pc4", i), PC4_M2W,    e.pc4);
            chk($sformatf("v%0d_alu", i), ALUout_M2W, e.alu);
            if (e.chk_dm) chk($sformatf("v%0d_dm", i), DMout_M2W, e.dm);
         end
      end

      // Mid-cycle asynchronous reset clears the bundle with no clock edge.
      #3;
      reset = 1'b0;
      #1;
      chk("async_ir",  IR_M2W,     32'h0);
      chk("async_pc4", PC4_M2W,    32'h0);
      chk("async_alu", ALUout_M2W, 32'h0);
      chk("async_dm",  DMout_M2W,  32'h0);

      // A store presented under reset must not write.
      IR_E2M = SW; PC4_E2M = 32'h2000; ALUout_E2M = 32'h10; RTdata_E2M = 32'h0BADF00D;
      #1;
      chk("rst_store_be",  {28'h0, DMbe}, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_ir", IR_M2W, 32'h0);

      // Release: the first edge captures the inputs unchanged.
      @(negedge clk);
      reset = 1'b1;
      IR_E2M = 32'h8C010004; PC4_E2M = 32'h2004; ALUout_E2M = 32'h10; RTdata_E2M = 32'h0;
      @(posedge clk);
      #1;
      chk("release_ir",  IR_M2W,     32'h8C010004);
      chk("release_pc4", PC4_M2W,    32'h2004);
      chk("release_dm",  DMout_M2W,  32'hDEADBEEF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule
